wb_pipe_slave_mem: RTL and testbench

Wishbone B4 pipelined-mode slave backed by an internal word memory. It responds to the SDRAM test bus master and acts as its bench counterpart and reference model. Every accepted request returns exactly one ack after a fixed latency, in order. Back-pressure comes from an outstanding-request limit and an optional periodic stall pattern, so the master's stall/ack handling is exercised.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_ack_delay_line.sv | 44 ++++
 rtl/wb_pipe_slave_mem.sv | 126 ++++++++++++
 tb/tb_wb_pipe_slave_mem.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and request/response records for the slave
// memory and its helpers.
package wb_pkg;

  localparam int WB_DW        = 32;
  localparam int WB_AW        = 32;
  localparam int WB_BYTE_STEP = 4;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic             ack;
    logic [WB_DW-1:0] data;
  } wb_rsp_t;

endpackage

// File: rtl/wb_ack_delay_line.sv
// Fixed-depth valid+payload shift register that turns accepted requests
// into acks DEPTH cycles later; a flush drops everything in flight.
module wb_ack_delay_line #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_flush,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic         r_vld_p  [DEPTH];
  logic [W-1:0] r_data_p [DEPTH];

  // Payload is zeroed with its valid so an idle output reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_data_p[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_data_p[i] <= '0;
      end
    end else begin
      r_vld_p[0]  <= i_vld;
      r_data_p[0] <= i_vld ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_data_p[i] <= r_data_p[i-1];
      end
    end
  end

  assign o_vld  = r_vld_p[DEPTH-1];
  assign o_data = r_data_p[DEPTH-1];

endmodule

// File: rtl/wb_pipe_slave_mem.sv
// Wishbone B4 pipelined slave over a word memory: fixed-latency in-order
// acks, back-pressure from an outstanding limit and an optional stall pattern.
module wb_pipe_slave_mem
  import wb_pkg::*;
#(
  parameter int MEM_AW          = 10,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STALL_PERIOD    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [WB_AW-1:0] addr_i,
  input  logic [WB_DW-1:0] data_i,
  output logic [WB_DW-1:0] data_o,
  output logic             stall_o,
  output logic             ack_o,
  output logic [4:0]       outstanding_o,
  output logic [15:0]      wr_cnt_o,
  output logic [15:0]      rd_cnt_o
);

  localparam int         OFS   = $clog2(WB_BYTE_STEP);
  localparam int         LW    = WB_DW + 1;
  localparam logic [4:0] MAX_O = 5'(MAX_OUTSTANDING);

  logic [WB_DW-1:0] r_mem [2**MEM_AW];

  wb_req_t          w_req;
  wb_rsp_t          w_rsp;
  logic [MEM_AW-1:0] w_idx;
  logic             w_acc;
  logic             w_flush;
  logic             w_ack;
  logic             w_pat_next;
  logic [LW-1:0]    w_line_in;
  logic [LW-1:0]    w_line_out;
  logic [4:0]       w_out_next;
  logic [4:0]       r_out;
  logic             r_stall;
  logic [15:0]      r_wr_cnt;
  logic [15:0]      r_rd_cnt;
  logic             w_unused;

  assign w_req   = '{we: we_i, addr: addr_i, data: data_i};
  assign w_idx   = w_req.addr[OFS +: MEM_AW];
  assign w_acc   = reset_n & cyc_i & stb_i & ~r_stall;
  assign w_flush = ~cyc_i;

  // Read data is sampled at acceptance and rides with the request.
  assign w_line_in = {w_req.we, w_req.we ? {WB_DW{1'b0}} : r_mem[w_idx]};

  always_ff @(posedge clk) begin
    if (w_acc && w_req.we) r_mem[w_idx] <= w_req.data;
  end

  wb_ack_delay_line #(
    .DEPTH (LATENCY),
    .W     (LW)
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_flush),
    .i_vld   (w_acc),
    .i_data  (w_line_in),
    .o_vld   (w_ack),
    .o_data  (w_line_out)
  );

  assign w_rsp   = '{ack: w_ack, data: w_line_out[WB_DW-1:0]};
  assign ack_o   = w_rsp.ack;
  assign data_o  = w_rsp.data;

  always_comb begin
    w_out_next = r_out;
    if (w_flush)             w_out_next = '0;
    else if (w_acc && !w_ack) w_out_next = r_out + 5'd1;
    else if (!w_acc && w_ack) w_out_next = r_out - 5'd1;
  end

  generate
    if (STALL_PERIOD >= 2) begin : g_pat
      localparam int          PW     = $clog2(STALL_PERIOD);
      localparam logic [PW-1:0] P_LAST = PW'(STALL_PERIOD - 1);
      logic [PW-1:0] r_pat_cnt;
      logic [PW-1:0] w_pat_cnt_next;

      assign w_pat_cnt_next = (r_pat_cnt == P_LAST) ? '0 : r_pat_cnt + PW'(1);
      assign w_pat_next     = (w_pat_cnt_next == P_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pat_cnt <= '0;
        else          r_pat_cnt <= w_pat_cnt_next;
      end
    end else begin : g_no_pat
      assign w_pat_next = 1'b0;
    end
  endgenerate

  // Stall is registered from next-cycle state so it never glitches on inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out    <= '0;
      r_stall  <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_out   <= w_out_next;
      r_stall <= (w_out_next >= MAX_O) | w_pat_next;
      if (w_acc &&  w_req.we) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_acc && !w_req.we) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign stall_o       = r_stall;
  assign outstanding_o = r_out;
  assign wr_cnt_o      = r_wr_cnt;
  assign rd_cnt_o      = r_rd_cnt;

  assign w_unused = ^{w_req.addr[WB_AW-1:MEM_AW+OFS], w_req.addr[OFS-1:0],
                      w_line_out[LW-1]};

endmodule

// File: tb/tb_wb_pipe_slave_mem.sv
// Bench for wb_pipe_slave_mem: three parameterisations share one bus and are
// each checked every cycle against a transaction-level model.
module tb_wb_pipe_slave_mem;

  localparam int N   = 3;
  localparam int LAT = 4;

  int MAXO [N] = '{8, 2, 8};
  int PER  [N] = '{0, 0, 4};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;

  logic [31:0] data_w  [N];
  logic        stall_w [N];
  logic        ack_w   [N];
  logic [4:0]  out_w   [N];
  logic [15:0] wr_w    [N];
  logic [15:0] rd_w    [N];

  always #5 clk = ~clk;

  wb_pipe_slave_mem #(.MEM_AW(10), .LATENCY(LAT), .MAX_OUTSTANDING(8), .STALL_PERIOD(0)) u_a (
    .clk(clk), .reset_n(reset_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_w[0]), .stall_o(stall_w[0]),
    .ack_o(ack_w[0]), .outstanding_o(out_w[0]), .wr_cnt_o(wr_w[0]), .rd_cnt_o(rd_w[0]));

  wb_pipe_slave_mem #(.MEM_AW(10), .LATENCY(LAT), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u_b (
    .clk(clk), .reset_n(reset_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_w[1]), .stall_o(stall_w[1]),
    .ack_o(ack_w[1]), .outstanding_o(out_w[1]), .wr_cnt_o(wr_w[1]), .rd_cnt_o(rd_w[1]));

  wb_pipe_slave_mem #(.MEM_AW(10), .LATENCY(LAT), .MAX_OUTSTANDING(8), .STALL_PERIOD(4)) u_c (
    .clk(clk), .reset_n(reset_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_w[2]), .stall_o(stall_w[2]),
    .ack_o(ack_w[2]), .outstanding_o(out_w[2]), .wr_cnt_o(wr_w[2]), .rd_cnt_o(rd_w[2]));

  // Reference state: memory image, ack schedule indexed by due cycle, counts.
  bit          exp_ack  [N][8];
  logic [31:0] exp_data [N][8];
  logic [31:0] mem_m    [N][1024];
  int          out_m    [N];
  logic [15:0] wr_m     [N];
  logic [15:0] rd_m     [N];
  int          pcnt     [N];
  bit          stall_m  [N];
  int          peak     [N];
  int          cyc_n;
  int          checks;
  int          failures;
  int          acks_a;
  logic [31:0] last_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 8; j++) exp_ack[k][j] = 1'b0;
      out_m[k]   = 0;
      wr_m[k]    = '0;
      rd_m[k]    = '0;
      pcnt[k]    = 0;
      stall_m[k] = 1'b0;
    end
  endtask

  task automatic check_and_model();
    int       s, d;
    bit       acc, ackn;
    logic [9:0] idx;
    s = cyc_n % 8;
    d = (cyc_n + LAT) % 8;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("ack%0d", k), 32'(ack_w[k]), 32'(exp_ack[k][s]));
      if (exp_ack[k][s]) chk($sformatf("data%0d", k), data_w[k], exp_data[k][s]);
      chk($sformatf("stall%0d", k), 32'(stall_w[k]), 32'(stall_m[k]));
      chk($sformatf("outst%0d", k), 32'(out_w[k]), out_m[k]);
      chk($sformatf("wrcnt%0d", k), 32'(wr_w[k]), 32'(wr_m[k]));
      chk($sformatf("rdcnt%0d", k), 32'(rd_w[k]), 32'(rd_m[k]));
      if (int'(out_w[k]) > peak[k]) peak[k] = int'(out_w[k]);
      if (k == 0 && ack_w[0] === 1'b1) begin
        acks_a++;
        last_a = data_w[0];
      end

      acc  = cyc_i && stb_i && !stall_m[k];
      idx  = addr_i[11:2];
      ackn = exp_ack[k][s];
      exp_ack[k][s] = 1'b0;
      if (acc) begin
        exp_ack[k][d] = 1'b1;
        if (we_i) begin
          exp_data[k][d] = '0;
          mem_m[k][idx]  = data_i;
          wr_m[k]++;
        end else begin
          exp_data[k][d] = mem_m[k][idx];
          rd_m[k]++;
        end
      end
      if (!cyc_i) begin
        for (int j = 0; j < 8; j++) exp_ack[k][j] = 1'b0;
        out_m[k] = 0;
      end else begin
        out_m[k] = out_m[k] + int'(acc) - int'(ackn);
      end
      if (PER[k] >= 2) pcnt[k] = (pcnt[k] + 1) % PER[k];
      stall_m[k] = (out_m[k] >= MAXO[k]) || (PER[k] >= 2 && pcnt[k] == PER[k] - 1);
    end
    cyc_n++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] dd);
    cyc_i  = c;
    stb_i  = s;
    we_i   = w;
    addr_i = a;
    data_i = dd;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rst_checks(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_ack%0d", tag, k), 32'(ack_w[k]), 32'h0);
      chk($sformatf("%s_stall%0d", tag, k), 32'(stall_w[k]), 32'h0);
      chk($sformatf("%s_outst%0d", tag, k), 32'(out_w[k]), 32'h0);
      chk($sformatf("%s_data%0d", tag, k), data_w[k], 32'h0);
      chk($sformatf("%s_cnt%0d", tag, k), {wr_w[k], rd_w[k]}, 32'h0);
    end
  endtask

  task automatic end_reset(input string tag);
    @(posedge clk);
    #1;
    rst_checks(tag);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] rc;
    checks   = 0;
    failures = 0;
    cyc_n    = 0;
    acks_a   = 0;
    last_a   = '0;
    for (int k = 0; k < N; k++) begin
      peak[k] = 0;
      for (int j = 0; j < 1024; j++) mem_m[k][j] = '0;
    end
    model_reset();

    end_reset("rst0");

    // Single write then read back.
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5_0001);
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    idle(5);
    chk("t1_rdata", last_a, 32'hA5A5_0001);
    chk("t1_wr", 32'(wr_w[0]), 32'd1);
    chk("t1_rd", 32'(rd_w[0]), 32'd1);

    // Back-to-back writes and reads.
    peak[0] = 0;
    acks_a  = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(6);
    chk("t2_peak", peak[0], 32'd4);
    chk("t2_acks", acks_a, 32'd32);
    chk("t2_last", last_a, 32'd16);

    // Continuous reads against the outstanding limit.
    peak[1] = 0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(6);
    chk("t3_peak_b", peak[1], 32'd2);

    // Stall pattern on an idle bus, then a request held across a stall.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (stall_w[2] === 1'b1) n++;
      idle(1);
    end
    chk("t4_pattern", n, 32'd3);
    for (int i = 0; i < 8 && !stall_m[2]; i++) idle(1);
    chk("t4_sync", 32'(stall_w[2]), 32'd1);
    rc = rd_w[2];
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("t4_hold", 32'(rd_w[2]), 32'(rc + 16'd1));
    idle(5);

    // Abort: three writes then cyc_i drops.
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'd7);
    drive(1'b1, 1'b1, 1'b1, 32'h24, 32'd8);
    drive(1'b1, 1'b1, 1'b1, 32'h28, 32'd9);
    acks_a = 0;
    repeat (6) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_noack", acks_a, 32'd0);
    chk("t5_outst", 32'(out_w[0]), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h28, 32'h0);
    idle(5);
    chk("t5_rd", last_a, 32'd9);

    // Reset with reads in flight.
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h28, 32'h0);
    idle(1);
    chk("t6_ack_pre", 32'(ack_w[0]), 32'd1);
    cyc_i   = 1'b0;
    stb_i   = 1'b0;
    reset_n = 1'b0;
    #1;
    rst_checks("t6_async");
    end_reset("t6");
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    idle(5);
    chk("t6_keep", last_a, 32'd7);
    drive(1'b1, 1'b1, 1'b1, 32'h1000, 32'hDEAD_0001);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(5);
    chk("t6_alias", last_a, 32'hDEAD_0001);

    // Randomised traffic with aliasing upper address bits and aborts.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F03F, $urandom);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
